// File: rtl/vga_plot_buffer.sv
// vga_plot_buffer: clips plots to the screen, queues them, drains to the framebuffer.
// Optional PLOT_STATS_EN: live clip/write counters (tied to zero otherwise).
module vga_plot_buffer #(
  parameter int DEPTH    = 4,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  vga_x,
  input  logic [6:0]  vga_y,
  input  logic [2:0]  vga_colour,
  input  logic        vga_plot,
  output logic        in_ready,
  input  logic        frame_end,
  output logic [14:0] fb_addr,
  output logic [2:0]  fb_wdata,
  output logic        fb_we,
  input  logic        fb_ready,
  output logic        frame_flushed,
  output logic [15:0] clip_count,
  output logic [15:0] write_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUN     = 2'd1;
  localparam logic [1:0] DRAIN   = 2'd2;
  localparam logic [1:0] FLUSHED = 2'd3;

  logic [PW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  logic [14:0]   addr_mem_q [DEPTH];
  logic [2:0]    col_mem_q  [DEPTH];
  logic [1:0]    st_q, st_d;

  logic          full, accept, clip, push, pop;
  logic [14:0]   x15, y15, addr_c;

  assign full     = (cnt_q == CW'(DEPTH));
  assign in_ready = !full && !rst;
  assign accept   = vga_plot && in_ready;
  assign clip     = (int'(vga_x) >= SCREEN_W) || (int'(vga_y) >= SCREEN_H);
  assign push     = accept && !clip;
  assign fb_we    = (cnt_q != '0);
  assign pop      = fb_we && fb_ready;

  assign x15 = {7'd0, vga_x};
  assign y15 = {8'd0, vga_y};

  // linear address; shift-add form for the default 160-pixel width
  always_comb begin
    if (SCREEN_W == 160)
      addr_c = (y15 << 7) + (y15 << 5) + x15;
    else
      addr_c = 15'((y15 * SCREEN_W) + x15);
  end

  assign fb_addr  = fb_we ? addr_mem_q[rp_q] : 15'd0;
  assign fb_wdata = fb_we ? col_mem_q[rp_q]  : 3'd0;

  // FIFO storage, written only on push
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem_q[wp_q] <= addr_c;
      col_mem_q[wp_q]  <= vga_colour;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + PW'(1);
      if (pop)  rp_q <= rp_q + PW'(1);
      if (push && !pop)
        cnt_q <= cnt_q + CW'(1);
      else if (pop && !push)
        cnt_q <= cnt_q - CW'(1);
    end
  end

  // frame tracking next state
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE: begin
        if (accept)
          st_d = frame_end ? DRAIN : RUN;
        else if (frame_end)
          st_d = FLUSHED;
      end
      RUN:     if (frame_end) st_d = DRAIN;
      DRAIN:   if (!fb_we && !push) st_d = FLUSHED;
      FLUSHED: st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  // frame tracking state register
  always_ff @(posedge clk) begin
    if (rst) st_q <= IDLE;
    else     st_q <= st_d;
  end

  assign frame_flushed = (st_q == FLUSHED);

`ifdef PLOT_STATS_EN
  logic [15:0] clip_q, wr_q;

  // saturating statistics counters
  always_ff @(posedge clk) begin
    if (rst) begin
      clip_q <= '0;
      wr_q   <= '0;
    end else begin
      if (accept && clip && clip_q != 16'hFFFF)
        clip_q <= clip_q + 16'd1;
      if (pop && wr_q != 16'hFFFF)
        wr_q <= wr_q + 16'd1;
    end
  end

  assign clip_count  = clip_q;
  assign write_count = wr_q;
`else
  assign clip_count  = 16'd0;
  assign write_count = 16'd0;
`endif

endmodule

// File: tb/tb_vga_plot_buffer.sv
// tb_vga_plot_buffer: vector table, directed corner sequences and random traffic
// checked against a queue-based model of the plot buffer.
module tb_vga_plot_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic        in_ready;
  logic        frame_end;
  logic [14:0] fb_addr;
  logic [2:0]  fb_wdata;
  logic        fb_we;
  logic        fb_ready;
  logic        frame_flushed;
  logic [15:0] clip_count;
  logic [15:0] write_count;

  vga_plot_buffer dut (
    .clk(clk), .rst(rst),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .in_ready(in_ready), .frame_end(frame_end),
    .fb_addr(fb_addr), .fb_wdata(fb_wdata), .fb_we(fb_we),
    .fb_ready(fb_ready), .frame_flushed(frame_flushed),
    .clip_count(clip_count), .write_count(write_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: pending writes as a queue, frame phase as a number
  int mq[$];
  int mode;    // 0 idle, 1 frame open, 2 draining, 3 flushed pulse
  int m_clip;
  int m_wr;
  bit last_acc;
  int nwrites;
  int flushes;

  typedef struct {
    int x;
    int y;
    int c;
    int addr;
    bit clipped;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_stat(input int v);
`ifdef PLOT_STATS_EN
    return v;
`else
    return 0;
`endif
  endfunction

  // compare one cycle, advance model and clock
  task automatic step();
    int  sz, head;
    bit  acc, clp, psh, pp;
    #1;
    sz   = mq.size();
    head = (sz > 0) ? mq[0] : 0;
    chk("in_ready", 32'(in_ready), 32'(!rst && sz < DEPTH));
    chk("fb_we", 32'(fb_we), 32'(sz > 0));
    chk("fb_addr", 32'(fb_addr), 32'(head >> 3));
    chk("fb_wdata", 32'(fb_wdata), 32'(head & 7));
    chk("frame_flushed", 32'(frame_flushed), 32'(mode == 3));
    chk("clip_count", 32'(clip_count), 32'(exp_stat(m_clip)));
    chk("write_count", 32'(write_count), 32'(exp_stat(m_wr)));
    if (fb_we === 1'b1 && fb_ready) nwrites++;
    if (frame_flushed === 1'b1) flushes++;
    acc = 1'b0;
    if (rst) begin
      mq.delete();
      mode   = 0;
      m_clip = 0;
      m_wr   = 0;
    end else begin
      acc = vga_plot && (sz < DEPTH);
      clp = (vga_x >= 160) || (vga_y >= 120);
      psh = acc && !clp;
      pp  = (sz > 0) && fb_ready;
      case (mode)
        0: if (acc) mode = frame_end ? 2 : 1;
           else if (frame_end) mode = 3;
        1: if (frame_end) mode = 2;
        2: if (sz == 0 && !psh) mode = 3;
        default: mode = 0;
      endcase
      if (pp) begin
        void'(mq.pop_front());
        m_wr++;
      end
      if (psh) mq.push_back((int'(vga_y) * 160 + int'(vga_x)) * 8 + int'(vga_colour));
      if (acc && clp) m_clip++;
    end
    last_acc = acc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    vga_plot = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input int x, input int y, input int c, input bit rnd);
    vga_x      = 8'(x);
    vga_y      = 7'(y);
    vga_colour = 3'(c);
    vga_plot   = 1'b1;
    last_acc   = 1'b0;
    for (int k = 0; k < 64; k++) begin
      if (rnd) fb_ready = 1'($urandom % 2);
      step();
      if (last_acc) break;
    end
    if (!last_acc) chk("accept_timeout", 0, 1);
    vga_plot = 1'b0;
  endtask

  task automatic drain(input bit rnd);
    int k;
    vga_plot = 1'b0;
    for (k = 0; k < 400; k++) begin
      if (mq.size() == 0 && mode == 0) break;
      fb_ready = rnd ? 1'($urandom % 2) : 1'b1;
      step();
    end
    if (k == 400) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    int nxt, ncl;

    vt[0] = '{0,   0,   5, 0,     1'b0};
    vt[1] = '{159, 119, 7, 19199, 1'b0};
    vt[2] = '{160, 0,   1, 0,     1'b1};
    vt[3] = '{0,   120, 2, 0,     1'b1};
    vt[4] = '{1,   1,   3, 161,   1'b0};
    vt[5] = '{255, 127, 6, 0,     1'b1};
    vt[6] = '{10,  3,   4, 490,   1'b0};
    vt[7] = '{159, 0,   1, 159,   1'b0};

    rst = 1'b1; vga_x = '0; vga_y = '0; vga_colour = '0;
    vga_plot = 1'b0; frame_end = 1'b0; fb_ready = 1'b1;
    mode = 0; m_clip = 0; m_wr = 0; nwrites = 0; flushes = 0;
    @(posedge clk);
    @(negedge clk);
    step();
    #1;
    chk("reset_fb_we", 32'(fb_we), 0);
    chk("reset_in_ready", 32'(in_ready), 0);
    chk("reset_flushed", 32'(frame_flushed), 0);
    chk("reset_fb_addr", 32'(fb_addr), 0);
    rst = 1'b0;
    idle(1);

    // single plots from the vector table
    ncl = 0;
    fb_ready = 1'b1;
    foreach (vt[i]) begin
      send(vt[i].x, vt[i].y, vt[i].c, 1'b0);
      #1;
      chk("vec_we", 32'(fb_we), 32'(!vt[i].clipped));
      if (!vt[i].clipped) begin
        chk("vec_addr", 32'(fb_addr), 32'(vt[i].addr));
        chk("vec_colour", 32'(fb_wdata), 32'(vt[i].c));
      end else begin
        ncl++;
      end
      idle(1);
      chk("vec_empty", 32'(fb_we), 0);
    end
    chk("vec_clips", 32'(clip_count), 32'(exp_stat(ncl)));

    // backpressure: fill, stall, then release
    rst = 1'b1; step(); rst = 1'b0;
    fb_ready = 1'b0;
    nxt = 0;
    vga_plot = 1'b1;
    for (int i = 0; i < 8; i++) begin
      vga_x = 8'(nxt); vga_y = 7'd2; vga_colour = 3'(nxt);
      step();
      if (last_acc) nxt++;
    end
    #1;
    chk("bp_accepts", 32'(nxt), 4);
    chk("bp_in_ready", 32'(in_ready), 0);
    fb_ready = 1'b1;
    for (int i = 0; i < 20 && nxt < 6; i++) begin
      vga_x = 8'(nxt); vga_y = 7'd2; vga_colour = 3'(nxt);
      step();
      if (last_acc) nxt++;
    end
    chk("bp_resume", 32'(nxt), 6);
    frame_end = 1'b1; idle(1); frame_end = 1'b0;
    drain(1'b0);

    // full screen fill with random backpressure
    rst = 1'b1; step(); rst = 1'b0;
    nwrites = 0; flushes = 0;
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++)
        send(x, y, x % 8, 1'b1);
    frame_end = 1'b1;
    fb_ready = 1'($urandom % 2);
    step();
    frame_end = 1'b0;
    drain(1'b1);
    idle(2);
    chk("fill_writes", 32'(nwrites), 19200);
    chk("fill_flushes", 32'(flushes), 1);
    chk("fill_write_count", 32'(write_count), 32'(exp_stat(19200)));

    // empty frame
    fb_ready = 1'b1;
    nwrites = 0; flushes = 0;
    frame_end = 1'b1; step(); frame_end = 1'b0;
    idle(4);
    chk("empty_flushes", 32'(flushes), 1);
    chk("empty_writes", 32'(nwrites), 0);

    // frame_end together with the last plot, write held off
    nwrites = 0; flushes = 0;
    fb_ready = 1'b0;
    vga_x = 8'd3; vga_y = 7'd4; vga_colour = 3'd6;
    vga_plot = 1'b1; frame_end = 1'b1;
    step();
    vga_plot = 1'b0; frame_end = 1'b0;
    idle(5);
    chk("late_no_flush", 32'(flushes), 0);
    fb_ready = 1'b1;
    idle(4);
    chk("late_flushes", 32'(flushes), 1);
    chk("late_writes", 32'(nwrites), 1);

    // reset with three entries queued
    fb_ready = 1'b0;
    send(5, 5, 1, 1'b0);
    send(6, 5, 2, 1'b0);
    send(7, 5, 3, 1'b0);
    send(200, 5, 3, 1'b0);
    rst = 1'b1;
    step();
    #1;
    chk("rst_fb_we", 32'(fb_we), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_clip", 32'(clip_count), 0);
    chk("rst_write", 32'(write_count), 0);
    rst = 1'b0;
    fb_ready = 1'b1;
    nwrites = 0;
    idle(5);
    chk("rst_no_stale", 32'(nwrites), 0);

    // random traffic, producer holds a refused plot
    vga_plot = 1'b0;
    last_acc = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!vga_plot || last_acc) begin
        vga_plot   = ($urandom % 3) != 0;
        vga_x      = 8'($urandom % 200);
        vga_y      = 7'($urandom % 140);
        vga_colour = 3'($urandom % 8);
      end
      frame_end = ($urandom % 50) == 0;
      fb_ready  = ($urandom % 4) != 0;
      step();
    end
    frame_end = 1'b0;
    vga_plot = 1'b0;
    frame_end = 1'b1; step(); frame_end = 1'b0;
    drain(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
